// File: rtl/pipa_pulse_source.sv
// pipa_pulse_source: three-axis PIPA emulator, sigma-delta torque pulses.
// Build option: define PIPA_BINARY_EN for binary (always-pulse) torquing.
module pipa_pulse_source #(
  parameter int RATE_W  = 12,
  parameter int ACC_W   = 16,
  parameter int THRESH  = 1024,
  parameter int PULSE_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    interrog,
  input  logic signed [RATE_W-1:0] rate_x,
  input  logic signed [RATE_W-1:0] rate_y,
  input  logic signed [RATE_W-1:0] rate_z,
  input  logic                    clr_counts,
  output logic                    PIPGXp,
  output logic                    PIPGXm,
  output logic                    PIPGYp,
  output logic                    PIPGYm,
  output logic                    PIPGZp,
  output logic                    PIPGZm,
  output logic signed [CNT_W-1:0] net_x,
  output logic signed [CNT_W-1:0] net_y,
  output logic signed [CNT_W-1:0] net_z,
  output logic                    busy,
  output logic                    overrun
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_PULSE = 1'b1;

  localparam int WC_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [WC_W-1:0] W_LAST = WC_W'(PULSE_W - 1);

  // Working width leaves headroom above the accumulator for the
  // add and the threshold step before saturation.
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] TH_P = SW'(THRESH);
  localparam logic signed [SW-1:0] TH_N = -TH_P;
  localparam logic signed [SW-1:0] A_MAX =
    {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] A_MIN =
    {3'b111, {(ACC_W-1){1'b0}}};

  // One sigma-delta update: returns {plus, minus, next_acc}.
  function automatic logic [ACC_W+1:0] axis_step(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [RATE_W-1:0] r
  );
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] n;
    logic                 p;
    logic                 m;
    s = SW'(a) + SW'(r);
    p = 1'b0;
    m = 1'b0;
    n = s;
`ifdef PIPA_BINARY_EN
    if (!s[SW-1]) begin
      p = 1'b1;
      n = s - TH_P;
    end else begin
      m = 1'b1;
      n = s + TH_P;
    end
`else
    if (s >= TH_P) begin
      p = 1'b1;
      n = s - TH_P;
    end else if (s <= TH_N) begin
      m = 1'b1;
      n = s + TH_P;
    end
`endif
    if (n > A_MAX) begin
      n = A_MAX;
    end else if (n < A_MIN) begin
      n = A_MIN;
    end
    return {p, m, n[ACC_W-1:0]};
  endfunction

  function automatic logic [CNT_W-1:0] delta(
    input logic p,
    input logic m
  );
    if (p) return CNT_W'(1);
    else if (m) return '1;
    else return '0;
  endfunction

  logic [0:0]              state;
  logic [WC_W-1:0]         wcnt;
  logic                    irq_q;
  logic                    sample;
  logic                    start;
  logic                    win_end;
  logic signed [ACC_W-1:0] acc_x;
  logic signed [ACC_W-1:0] acc_y;
  logic signed [ACC_W-1:0] acc_z;
  logic [ACC_W+1:0]        nx_x;
  logic [ACC_W+1:0]        nx_y;
  logic [ACC_W+1:0]        nx_z;

  assign sample  = interrog & ~irq_q;
  assign busy    = (state == S_PULSE);
  assign start   = sample & enable & ~busy;
  assign win_end = busy & (wcnt == W_LAST);

  assign nx_x = axis_step(acc_x, rate_x);
  assign nx_y = axis_step(acc_y, rate_y);
  assign nx_z = axis_step(acc_z, rate_z);

  // Interrogation edge register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= interrog;
  end

  // Window FSM: IDLE until an accepted sample, then PULSE_W cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_PULSE;
            wcnt  <= '0;
          end
        end
        S_PULSE: begin
          if (wcnt == W_LAST) begin
            state <= S_IDLE;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + WC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered pulse lines, held for the whole shared window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {PIPGXp, PIPGXm} <= 2'b00;
      {PIPGYp, PIPGYm} <= 2'b00;
      {PIPGZp, PIPGZm} <= 2'b00;
    end else if (start) begin
      {PIPGXp, PIPGXm} <= nx_x[ACC_W+1:ACC_W];
      {PIPGYp, PIPGYm} <= nx_y[ACC_W+1:ACC_W];
      {PIPGZp, PIPGZm} <= nx_z[ACC_W+1:ACC_W];
    end else if (win_end) begin
      {PIPGXp, PIPGXm} <= 2'b00;
      {PIPGYp, PIPGYm} <= 2'b00;
      {PIPGZp, PIPGZm} <= 2'b00;
    end
  end

  // Accumulators move only on an accepted sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_x <= '0;
      acc_y <= '0;
      acc_z <= '0;
    end else if (start) begin
      acc_x <= nx_x[ACC_W-1:0];
      acc_y <= nx_y[ACC_W-1:0];
      acc_z <= nx_z[ACC_W-1:0];
    end
  end

  // Net pulse counters and sticky overrun; clear beats a new pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      net_x   <= '0;
      net_y   <= '0;
      net_z   <= '0;
      overrun <= 1'b0;
    end else if (clr_counts) begin
      net_x   <= '0;
      net_y   <= '0;
      net_z   <= '0;
      overrun <= 1'b0;
    end else begin
      if (start) begin
        net_x <= net_x + delta(nx_x[ACC_W+1], nx_x[ACC_W]);
        net_y <= net_y + delta(nx_y[ACC_W+1], nx_y[ACC_W]);
        net_z <= net_z + delta(nx_z[ACC_W+1], nx_z[ACC_W]);
      end
      if (sample && enable && busy) overrun <= 1'b1;
    end
  end

endmodule
